float_divider: RTL

FLOAT_DIVIDER -- requirements
Module: float_divider

---
 rtl/float_pkg.sv | 11 +
 rtl/fp_classify.sv | 21 ++
 rtl/float_divider.sv | 136 +++++++++++++
 3 files changed

// File: rtl/float_pkg.sv
// Shared binary32 field constants and divider FSM state encoding.
package float_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam int DIV_CYCLES = 25;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;
endpackage

// File: rtl/fp_classify.sv
// Combinational binary32 classifier; exponent-0 words (denormals) count as zero.
module fp_classify
  import float_pkg::*;
(
  input  logic [31:0] x,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             unused_sign;

  assign exp_f       = x[MAN_W +: EXP_W];
  assign man_f       = x[MAN_W-1:0];
  assign unused_sign = x[31];

  assign is_zero = (exp_f == '0);
  assign is_inf  = (exp_f == '1) && (man_f == '0);
  assign is_nan  = (exp_f == '1) && (man_f != '0);
endmodule

// File: rtl/float_divider.sv
// Iterative binary32 divider: restoring division, one quotient bit per cycle, truncating.
module float_divider
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  flags
);
  state_t state, state_nxt;

  logic               sign;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W+1:0]   rem;
  logic [MAN_W:0]     mb;
  logic [MAN_W+1:0]   quo;
  logic [4:0]         cnt;
  logic [MAN_W+1:0]   diff;
  logic               take;

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;
  logic        in_sign;
  logic        special;
  logic [31:0] special_res;
  logic [3:0]  special_flags;

  fp_classify u_cls_a (.x(a), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
  fp_classify u_cls_b (.x(b), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

  // Exponent rebias and saturation to inf/zero; returns {result, flags}.
  function automatic logic [35:0] norm_pack(input logic s, input logic [EXP_W-1:0] ea_f,
                                            input logic [EXP_W-1:0] eb_f, input logic [MAN_W+1:0] q);
    logic signed [9:0]  e;
    logic [MAN_W-1:0]   man;
    e = $signed({2'b00, ea_f}) - $signed({2'b00, eb_f})
        + (q[MAN_W+1] ? $signed(10'(BIAS)) : $signed(10'(BIAS - 1)));
    man = q[MAN_W+1] ? q[MAN_W:1] : q[MAN_W-1:0];
    if (e >= 10'sd255)
      norm_pack = {s, POS_INF[30:0], 4'b0010};
    else if (e <= 10'sd0)
      norm_pack = {s, 31'd0, 4'b0001};
    else
      norm_pack = {s, e[EXP_W-1:0], man, 4'b0000};
  endfunction

  assign in_sign = a[31] ^ b[31];

  // Special operands resolve at accept; order below is the priority order.
  always_comb begin
    special       = 1'b1;
    special_res   = '0;
    special_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_res   = QNAN;
      special_flags = 4'b1000;
    end else if (b_zero && !a_inf) begin
      special_res   = {in_sign, POS_INF[30:0]};
      special_flags = 4'b0100;
    end else if (a_inf) begin
      special_res   = {in_sign, POS_INF[30:0]};
    end else if (a_zero || b_inf) begin
      special_res   = {in_sign, 31'd0};
    end else begin
      special       = 1'b0;
    end
  end

  assign diff = rem - {1'b0, mb};
  assign take = (rem >= {1'b0, mb});

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = special ? DONE : DIVIDE;
      DIVIDE:  if (cnt == 5'(DIV_CYCLES - 1)) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign   <= 1'b0;
      ea     <= '0;
      eb     <= '0;
      rem    <= '0;
      mb     <= '0;
      quo    <= '0;
      cnt    <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign  <= in_sign;
          ea    <= a[MAN_W +: EXP_W];
          eb    <= b[MAN_W +: EXP_W];
          rem   <= {2'b01, a[MAN_W-1:0]};
          mb    <= {1'b1, b[MAN_W-1:0]};
          quo   <= '0;
          cnt   <= '0;
          if (special) begin
            result <= special_res;
            flags  <= special_flags;
          end else begin
            flags  <= '0;
          end
        end
        DIVIDE: begin
          quo <= {quo[MAN_W:0], take};
          rem <= take ? {diff[MAN_W:0], 1'b0} : {rem[MAN_W:0], 1'b0};
          cnt <= cnt + 5'd1;
        end
        NORM:    {result, flags} <= norm_pack(sign, ea, eb, quo);
        DONE:    if (out_ready) flags <= '0;
        default: ;
      endcase
    end
  end
endmodule
